// File: rtl/ibex_mem_arbiter.sv
// Two-into-one req/gnt/rvalid arbiter: instruction fetch and load/store share
// one memory port. New requests are chosen round-robin (or data-first) and
// the choice is held until granted; in-order responses are steered back to
// their source with a small FIFO of source IDs.
module ibex_mem_arbiter #(
  parameter int unsigned MaxOutstanding = 2,
  parameter bit          DataPriority   = 1'b0
) (
  input  logic        CLK,
  input  logic        RST_N,

  input  logic        instr_req_i,
  output logic        instr_gnt_o,
  output logic        instr_rvalid_o,
  input  logic [31:0] instr_addr_i,
  output logic [31:0] instr_rdata_o,
  output logic [6:0]  instr_rdata_intg_o,
  output logic        instr_err_o,

  input  logic        data_req_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  input  logic [6:0]  data_wdata_intg_i,
  output logic [31:0] data_rdata_o,
  output logic [6:0]  data_rdata_intg_o,
  output logic        data_err_o,

  output logic        mem_req_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic [6:0]  mem_wdata_intg_o,
  input  logic [31:0] mem_rdata_i,
  input  logic [6:0]  mem_rdata_intg_i,
  input  logic        mem_err_i,

  output logic        unexpected_rvalid_o
);

  typedef enum logic [1:0] {
    IDLE,
    LOCK_I,
    LOCK_D
  } state_e;

  localparam logic [2:0] MaxCnt  = 3'(MaxOutstanding);
  localparam logic [1:0] LastPtr = 2'(MaxOutstanding - 1);

  state_e      state_q, state_d;
  logic        ready_q, ready_d;
  logic        last_grant_q, last_grant_d;   // 1 = data was granted last
  logic [3:0]  fifo_q, fifo_d;               // source IDs, 1 = data
  logic [1:0]  wr_ptr_q, wr_ptr_d;
  logic [1:0]  rd_ptr_q, rd_ptr_d;
  logic [2:0]  count_q, count_d;
  logic        unexp_q, unexp_d;

  logic        sel_data;
  logic        sel_req;
  logic        grant;
  logic        pop;
  logic        head_id;

  // Pick the requester to present: fresh arbitration in IDLE, held while locked
  always_comb begin
    sel_data = 1'b0;
    sel_req  = 1'b0;
    unique case (state_q)
      IDLE: begin
        sel_req = instr_req_i | data_req_i;
        if (instr_req_i && data_req_i) begin
          sel_data = DataPriority | ~last_grant_q;
        end else begin
          sel_data = data_req_i;
        end
      end
      LOCK_I: begin
        sel_req = instr_req_i;
      end
      LOCK_D: begin
        sel_data = 1'b1;
        sel_req  = data_req_i;
      end
      default: ;
    endcase
  end

  // Request path toward the shared port and grant fan-back
  always_comb begin
    mem_req_o   = ready_q & sel_req & (count_q < MaxCnt);
    grant       = mem_req_o & mem_gnt_i;
    instr_gnt_o = grant & ~sel_data;
    data_gnt_o  = grant & sel_data;
    if (sel_data) begin
      mem_we_o         = data_we_i;
      mem_be_o         = data_be_i;
      mem_addr_o       = data_addr_i;
      mem_wdata_o      = data_wdata_i;
      mem_wdata_intg_o = data_wdata_intg_i;
    end else begin
      mem_we_o         = 1'b0;
      mem_be_o         = 4'hF;
      mem_addr_o       = instr_addr_i;
      mem_wdata_o      = '0;
      mem_wdata_intg_o = '0;
    end
  end

  // Response steering by the oldest outstanding source ID
  always_comb begin
    head_id             = fifo_q[rd_ptr_q];
    pop                 = mem_rvalid_i & (count_q != '0);
    instr_rvalid_o      = pop & ~head_id;
    data_rvalid_o       = pop & head_id;
    instr_rdata_o       = instr_rvalid_o ? mem_rdata_i      : '0;
    instr_rdata_intg_o  = instr_rvalid_o ? mem_rdata_intg_i : '0;
    instr_err_o         = instr_rvalid_o & mem_err_i;
    data_rdata_o        = data_rvalid_o  ? mem_rdata_i      : '0;
    data_rdata_intg_o   = data_rvalid_o  ? mem_rdata_intg_i : '0;
    data_err_o          = data_rvalid_o  & mem_err_i;
    unexpected_rvalid_o = unexp_q;
  end

  // Lock until granted; a dropped request while locked abandons the lock
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (mem_req_o && !mem_gnt_i) begin
          state_d = sel_data ? LOCK_D : LOCK_I;
        end
      end
      LOCK_I, LOCK_D: begin
        if (!sel_req || grant) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // ID FIFO, round-robin history, readiness and sticky spurious-response flag
  always_comb begin
    fifo_d       = fifo_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    last_grant_d = last_grant_q;
    ready_d      = 1'b1;
    unexp_d      = unexp_q | (mem_rvalid_i & (count_q == '0));
    if (grant) begin
      fifo_d[wr_ptr_q] = sel_data;
      wr_ptr_d         = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + 2'd1;
      last_grant_d     = sel_data;
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + 2'd1;
    end
    count_d = count_q + {2'b00, grant} - {2'b00, pop};
  end

  // State registers
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q      <= IDLE;
      ready_q      <= 1'b0;
      last_grant_q <= 1'b0;
      fifo_q       <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      unexp_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      ready_q      <= ready_d;
      last_grant_q <= last_grant_d;
      fifo_q       <= fifo_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      unexp_q      <= unexp_d;
    end
  end

endmodule
